// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Greedy two-denomination coin hopper controller with inventory
//               tracking, coin-sense timeout and sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int TIMEOUT_CYC = 200,
  parameter int INV_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [2:0]       amount,
  input  logic             load,
  input  logic [INV_W-1:0] load_a,
  input  logic [INV_W-1:0] load_b,
  input  logic             coin_sense,
  output logic             eject_a,
  output logic             eject_b,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [2:0]       remaining,
  output logic [INV_W-1:0] inv_a,
  output logic [INV_W-1:0] inv_b
);

  localparam int                c_TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_EJECT    = 3'd2,
    S_WAIT_REL = 3'd3,
    S_DONE     = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [2:0]         r_rem,    w_rem_nxt;
  logic [INV_W-1:0]   r_inv_a,  w_inv_a_nxt;
  logic [INV_W-1:0]   r_inv_b,  w_inv_b_nxt;
  logic               r_coin_b, w_coin_b_nxt;
  logic [c_TMR_W-1:0] r_timer,  w_timer_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rem    <= 3'd0;
      r_inv_a  <= '0;
      r_inv_b  <= '0;
      r_coin_b <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_inv_a  <= w_inv_a_nxt;
      r_inv_b  <= w_inv_b_nxt;
      r_coin_b <= w_coin_b_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_inv_a_nxt  = r_inv_a;
    w_inv_b_nxt  = r_inv_b;
    w_coin_b_nxt = r_coin_b;
    w_timer_nxt  = r_timer;
    case (r_state)
      S_IDLE, S_FAULT: begin
        // load outranks req; a FAULT state never accepts a new request
        if (load) begin
          w_inv_a_nxt = load_a;
          w_inv_b_nxt = load_b;
          w_state_nxt = S_IDLE;
        end else if (r_state == S_IDLE && req) begin
          w_rem_nxt   = amount;
          w_state_nxt = (amount > 3'd4) ? S_FAULT : S_SELECT;
        end
      end
      S_SELECT: begin
        if (r_rem == 3'd0) begin
          w_state_nxt = S_DONE;
        end else if (r_rem >= 3'd2 && r_inv_b != '0) begin
          w_state_nxt  = S_EJECT;
          w_coin_b_nxt = 1'b1;
          w_timer_nxt  = '0;
        end else if (r_inv_a != '0) begin
          w_state_nxt  = S_EJECT;
          w_coin_b_nxt = 1'b0;
          w_timer_nxt  = '0;
        end else begin
          w_state_nxt = S_FAULT;
        end
      end
      S_EJECT: begin
        if (coin_sense) begin
          w_state_nxt = S_WAIT_REL;
          w_timer_nxt = '0;
          if (r_coin_b) begin
            w_inv_b_nxt = r_inv_b - INV_W'(1);
            w_rem_nxt   = r_rem - 3'd2;
          end else begin
            w_inv_a_nxt = r_inv_a - INV_W'(1);
            w_rem_nxt   = r_rem - 3'd1;
          end
        end else if (r_timer == c_TMR_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_timer_nxt = r_timer + c_TMR_W'(1);
        end
      end
      S_WAIT_REL: begin
        if (!coin_sense) begin
          w_state_nxt = S_SELECT;
        end else if (r_timer == c_TMR_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_timer_nxt = r_timer + c_TMR_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of the state and data registers
  assign eject_a   = (r_state == S_EJECT) && !r_coin_b;
  assign eject_b   = (r_state == S_EJECT) &&  r_coin_b;
  assign busy      = (r_state == S_SELECT) || (r_state == S_EJECT) ||
                     (r_state == S_WAIT_REL) || (r_state == S_DONE);
  assign done      = (r_state == S_DONE);
  assign fault     = (r_state == S_FAULT);
  assign remaining = r_rem;
  assign inv_a     = r_inv_a;
  assign inv_b     = r_inv_b;

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 200: the maximum number of clk cycles to wait on coin_sense in any hopper phase.
REQ-002 SHALL have parameter INV_W, default 6: the width of each coin inventory counter.
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  one-cycle change request strobe.
REQ-006 SHALL have port amount  input  3  change owed, in small-coin units (1 unit = one coin A; one coin B = 2 units), sampled with req.
REQ-007 SHALL have port load  input  1  inventory load strobe.
REQ-008 SHALL have ports load_a and load_b  input  INV_W  coin A and coin B counts, sampled with load.
REQ-009 SHALL have port coin_sense  input  1  hopper exit sensor, high while a coin passes.
REQ-010 SHALL have ports eject_a and eject_b  output  1  hopper solenoid drives for coin A and coin B.
REQ-011 SHALL have ports busy, done and fault  output  1  each: dispensing in progress, one-cycle completion pulse, sticky error flag.
REQ-012 SHALL have port remaining  output  3  units still owed.
REQ-013 SHALL have ports inv_a and inv_b  output  INV_W  current coin inventories.

Function
REQ-014 SHALL implement FSM states IDLE, SELECT, EJECT, WAIT_REL, DONE and FAULT; all outputs SHALL decode from registers only, with no combinational input-to-output path.
REQ-015 IDLE: when req=1, SHALL latch amount into remaining and enter SELECT next cycle; req in any other state SHALL be ignored and SHALL NOT be queued.
REQ-016 IDLE with req=1 and amount>4 SHALL enter FAULT, with remaining=amount.
REQ-017 SELECT, greedy, single cycle, evaluated in this priority order:
- remaining=0 -> DONE
- remaining>=2 and inv_b>0 -> EJECT with coin B
- remaining>=1 and inv_a>0 -> EJECT with coin A
- otherwise -> FAULT, with remaining holding the shortfall
REQ-018 EJECT:
- SHALL hold the selected eject_x=1 and clear the timer on entry.
- On the first cycle coin_sense=1: SHALL deassert eject_x, decrement the matching inventory by 1, decrement remaining by the coin value (B=2, A=1), and enter WAIT_REL.
REQ-019 WAIT_REL SHALL wait for coin_sense=0 and then return to SELECT; the timer SHALL restart on entry.
REQ-020 Timeout: if EJECT or WAIT_REL reaches TIMEOUT_CYC cycles, SHALL enter FAULT, deassert eject_x, and leave inventory and remaining unchanged.
REQ-021 DONE SHALL assert done=1 for exactly one cycle and then enter IDLE.
REQ-022 busy SHALL be 1 in SELECT, EJECT, WAIT_REL and DONE, and 0 in IDLE and FAULT.
REQ-023 FAULT SHALL hold fault=1 until reset or load; partial dispensing already completed SHALL NOT be reverted.
REQ-024 Load handling:
- load in IDLE or FAULT SHALL write inv_a=load_a and inv_b=load_b, clear fault, and go to IDLE next cycle.
- load in any other state SHALL be ignored.
- load and req in the same IDLE cycle: load SHALL win and req SHALL be dropped.
REQ-025 Inventory counters SHALL never wrap below 0; SELECT guarantees that no eject is issued for an empty coin type.
REQ-026 Latency: req at cycle N SHALL give SELECT at N+1 and the first eject at N+2; each coin costs at least 3 cycles (EJECT, WAIT_REL, SELECT).
REQ-027 Only one eject output SHALL be high at any time.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE and set eject_a, eject_b, busy, done, fault to 0, remaining=0, and inv_a=inv_b=0.
REQ-029 reset asserted mid-operation, including EJECT, SHALL abort the operation with no done pulse; after release the block SHALL idle until the next load.

Verification
REQ-030 Scenario: load A=5/B=5, req amount=3, coin_sense pulsed 2 cycles per eject -> one eject_b then one eject_a, done pulse, inv_a=4, inv_b=4, remaining=0.
REQ-031 Scenario: inv A=10/B=0, req amount=4 -> exactly four eject_a pulses, no eject_b, done, inv_a=6.
REQ-032 Scenario: inv A=0/B=1, req amount=3 -> one eject_b, then fault=1, remaining=1, busy=0; a following load clears fault.
REQ-033 Scenario: coin_sense held 0 after eject_b -> fault exactly TIMEOUT_CYC cycles after eject assertion, eject_b=0, inv_b unchanged.
REQ-034 Scenario: req amount=0 -> done at N+2 with no ejects; req amount=6 -> fault at N+1; second req while busy -> ignored.
REQ-035 Scenario: reset pulsed low during EJECT -> eject and busy 0 in the same cycle, inventories 0, no done pulse.
